// File: rtl/lsu_mem_responder.sv
// ---------------------------------------------------------------------------
// lsu_mem_responder
//
// Memory-side responder for the core's load/store control. It accepts one
// request from execute (i_memReq/i_memWrite/i_funct3), stalls the core while
// busy, issues a single word-aligned bus transaction with byte strobes, and
// returns sign-/zero-extended load data or a fault flag with a one-cycle
// o_done pulse.
//
// Optional feature (compile-time macro LSU_TIMEOUT_EN):
//   when defined, a response-wait counter aborts the access with
//   o_accessFault after TIMEOUT_CYC cycles in REQ+RESP. When undefined the
//   FSM waits for the bus indefinitely.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_memReq/i_memWrite       request (held until o_done), 1 = store
//   i_funct3                  [1:0] size B/H/W/illegal, [2] zero-extend loads
//   i_addr, i_wdata           byte address, right-aligned store data
//   o_stall, o_done           pipeline freeze, completion pulse
//   o_rdata                   extended load result (held until next load)
//   o_misaligned              misaligned/illegal-size fault, valid with o_done
//   o_accessFault             bus error or timeout, valid with o_done
//   o_busValid/o_busWrite     bus request and direction
//   o_busAddr/o_busWdata      word address, lane-replicated store data
//   o_busWstrb                byte enables (0000 for loads)
//   i_busReady                bus accepts the request
//   i_busRvalid/i_busRdata    response valid (reads and writes), read word
//   i_busErr                  bus error, qualified by i_busRvalid
// ---------------------------------------------------------------------------
module lsu_mem_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_memReq,
    input  logic              i_memWrite,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_misaligned,
    output logic              o_accessFault,
    output logic              o_busValid,
    output logic              o_busWrite,
    output logic [ADDR_W-1:0] o_busAddr,
    output logic [31:0]       o_busWdata,
    output logic [3:0]        o_busWstrb,
    input  logic              i_busReady,
    input  logic              i_busRvalid,
    input  logic [31:0]       i_busRdata,
    input  logic              i_busErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strb_q;
    logic              valid_q;
    logic              done_q;
    logic              misal_q;
    logic              fault_q;
    logic [31:0]       rdata_q;

    logic              misal_d;
    logic [3:0]        strb_d;
    logic [31:0]       wdata_d;
    logic [15:0]       lane_d;
    logic [31:0]       load_d;
    logic              timeout_hit;

    // Request decode: alignment check, strobe and lane replication.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // branch would otherwise infer a latch.
        misal_d = 1'b0;
        strb_d  = 4'b1111;
        wdata_d = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                strb_d  = 4'b0001 << i_addr[1:0];
                wdata_d = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                strb_d  = 4'b0011 << i_addr[1:0];
                wdata_d = {2{i_wdata[15:0]}};
                misal_d = i_addr[0];
            end
            2'b10:   misal_d = (i_addr[1:0] != 2'b00);
            default: misal_d = 1'b1;
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend.
    always_comb begin
        lane_d = 16'(i_busRdata >> {off_q, 3'b000});
        load_d = i_busRdata;
        case (size_q)
            2'b00:   load_d = zext_q ? {24'd0, lane_d[7:0]}
                                     : {{24{lane_d[7]}}, lane_d[7:0]};
            2'b01:   load_d = zext_q ? {16'd0, lane_d}
                                     : {{16{lane_d[15]}}, lane_d};
            default: load_d = i_busRdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 256) ? $clog2(TIMEOUT_CYC) : 8;

    logic [CNT_W-1:0] cnt_q;

    // Held at zero outside REQ/RESP, so it restarts on every entry to REQ.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == RESP) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout_hit = (state_q == REQ || state_q == RESP) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Keeps the timeout parameter referenced when the counter is absent.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            zext_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            misal_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state_q)
                IDLE: begin
                    if (i_memReq) begin
                        if (misal_d) begin
                            misal_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
                            off_q   <= i_addr[1:0];
                            size_q  <= i_funct3[1:0];
                            zext_q  <= i_funct3[2];
                            write_q <= i_memWrite;
                            wdata_q <= i_memWrite ? wdata_d : 32'd0;
                            strb_q  <= i_memWrite ? strb_d  : 4'b0000;
                            valid_q <= 1'b1;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        valid_q <= 1'b0;
                        fault_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (i_busReady) begin
                        valid_q <= 1'b0;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (i_busRvalid) begin
                        // Stores and errored loads leave the last result alone.
                        if (!write_q && !i_busErr) begin
                            rdata_q <= load_d;
                        end
                        fault_q <= i_busErr;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (timeout_hit) begin
                        fault_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // i_memReq is still the finished instruction's request here.
                    done_q  <= 1'b0;
                    misal_q <= 1'b0;
                    fault_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall is combinational in IDLE so the core freezes on the request cycle.
    assign o_stall = i_rst_n & (((state_q == IDLE) & i_memReq) |
                                (state_q == REQ) | (state_q == RESP));

    assign o_done        = done_q;
    assign o_rdata       = rdata_q;
    assign o_misaligned  = misal_q;
    assign o_accessFault = fault_q;
    assign o_busValid    = valid_q;
    assign o_busWrite    = write_q;
    assign o_busAddr     = addr_q;
    assign o_busWdata    = wdata_q;
    assign o_busWstrb    = strb_q;

endmodule

// File: doc/lsu_mem_responder.md
Name: lsu_mem_responder

Overview:
- Memory-side responder for the core's load/store control: the `memReq`, `memWrite` and `funct3` outputs of main decode.
- Accepts one request from the execute stage and stalls the core while busy.
- Converts the request into a single word-aligned bus transaction with byte strobes, then returns sign-/zero-extended load data or a fault.
- Sits between the core datapath and the data-memory bus.

Parameters:
ADDR_W, 32, byte-address width.
TIMEOUT_CYC, 255, response-wait limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_memReq  input  1  load/store request, held by core until o_done
i_memWrite  input  1  1=store, 0=load
i_funct3  input  3  [1:0] size: 00=B, 01=H, 10=W, 11=illegal; [2]=1 selects zero-extend on loads
i_addr  input  ADDR_W  byte address
i_wdata  input  32  store data, right-aligned
o_stall  output  1  freeze core pipeline
o_done  output  1  one-cycle completion pulse
o_rdata  output  32  extended load result
o_misaligned  output  1  misaligned/illegal-size fault, valid with o_done
o_accessFault  output  1  bus error or timeout, valid with o_done
o_busValid  output  1  bus request valid
o_busWrite  output  1  bus write
o_busAddr  output  ADDR_W  word address, bits [1:0] = 0
o_busWdata  output  32  lane-replicated store data
o_busWstrb  output  4  byte enables
i_busReady  input  1  bus accepts request
i_busRvalid  input  1  response valid, for both reads and writes
i_busRdata  input  32  read word
i_busErr  input  1  error, qualified by i_busRvalid

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. Reset (asynchronous) → IDLE. All outputs 0 and all latched fields 0 on reset.
- Reset asserted mid-transaction: o_busValid falls immediately; the request is dropped and no o_done is produced.
- IDLE, i_memReq=1, aligned: latch address, size, sign, write, data and strobe; go to REQ.
- IDLE, i_memReq=1, misaligned: go to DONE with o_misaligned=1 and no bus access. Misaligned means H with addr[0]=1, W with addr[1:0]≠0, or size=11.
- REQ:
  - o_busValid=1; bus fields come only from registers and stay stable until i_busReady.
  - On i_busReady=1, go to RESP.
  - i_busRvalid is ignored in REQ.
- RESP: on i_busRvalid=1, register o_rdata (loads only) and o_accessFault=i_busErr; go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. i_memReq is ignored in DONE because it is the same instruction's request.
- o_stall = (IDLE & i_memReq) | REQ | RESP. In DONE, o_stall=0.
- Minimum latency, aligned access with ready and rvalid on the first possible cycles: request → o_done in 3 cycles.
- Store strobes: B → 0001<<addr[1:0]; H → 0011<<addr[1:0]; W → 1111.
- Store data: B replicates wdata[7:0] to all 4 lanes; H replicates wdata[15:0] twice; W passes unchanged.
- Load extraction: select byte/half lane by addr[1:0], then sign-extend if funct3[2]=0, else zero-extend. W passes unchanged.
- Register hold: o_rdata holds its value until the next completed load.
- Fault clearing: o_misaligned and o_accessFault clear on leaving DONE.
- For stores and faulted accesses, o_rdata is unchanged.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Enabled:
  - An 8+-bit counter resets on entering REQ and counts cycles spent in REQ plus RESP.
  - When the count reaches TIMEOUT_CYC, go to DONE with o_accessFault=1 and drop o_busValid.
  - A late i_busRvalid arriving afterwards in IDLE is ignored.
- Disabled: no counter; the FSM waits indefinitely.

Test Plan:
- LB addr 0x1003, bus rdata 0x80FF_1234 → strb 0000, busAddr 0x1000, o_rdata 0xFFFF_FF80; o_done 3 cycles after request.
- LHU addr 0x2002, rdata 0xBEEF_0000 → o_rdata 0x0000_BEEF; with funct3=001 (LH) → 0xFFFF_BEEF.
- SB addr 0x3001, wdata 0x1234_56AB → busWdata 0xABAB_ABAB, busWstrb 0010, busWrite 1; SH addr 0x3002 → strb 1100, busWdata 0x56AB_56AB.
- LW addr 0x4002 → o_misaligned=1 with o_done next cycle, o_busValid never asserted; size=11 also faults.
- i_busReady held low 5 cycles → o_busValid/addr/strb stable; o_stall=1 throughout; i_busErr=1 with rvalid → o_accessFault=1, o_rdata unchanged.
- i_rst_n low during RESP → o_busValid=0, o_stall=0, no o_done.
- With LSU_TIMEOUT_EN, no rvalid → o_accessFault with o_done after TIMEOUT_CYC cycles.
